mdio_phy_slave: RTL and testbench

PHY-side MDIO management responder (IEEE 802.3 Clause 22) and the counterpart to the station-management master in the Ethernet MDIO path. It oversamples `eth_mdc` and `eth_mdio` on the fabric clock and decodes preamble, ST, OP, PHYAD, REGAD and TA. It accepts write frames into an external register port and serves read frames by driving MDIO during turnaround and data. It provides an emulated PHY for loopback and bench use, and a management slave for FPGA-hosted PHY logic.

---
 rtl/mdio_pkg.sv | 25 ++
 rtl/mdio_edge_sync.sv | 33 +++
 rtl/mdio_phy_slave.sv | 199 +++++++++++++++++++
 tb/tb_mdio_phy_slave.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO Clause 22 frame constants, FSM state encoding and counter widths
// for the PHY-side management responder.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;

    localparam int PRE_CNT_W = 6;
    localparam int BIT_CNT_W = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_RD_TA1,
        S_RD_TA2,
        S_RD_DATA,
        S_WR_TA,
        S_WR_DATA
    } mdio_state_t;

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings MDC and MDIO into the fabric clock domain and flags each MDC rising edge.
// Both lines use equal depth so mdio_s is the value present when MDC rose.
module mdio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic eth_mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);

    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdio_sync;
    logic                   mdc_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_sync  <= '0;
            mdio_sync <= '1;
            mdc_prev  <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], eth_mdc};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
            mdc_prev  <= mdc_sync[SYNC_STAGES-1];
        end
    end

    assign mdc_rise = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
    assign mdio_s   = mdio_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_phy_slave.sv
// Clause 22 MDIO management responder: decodes frames on synchronized MDC rises,
// strobes writes into a register port and serves reads by driving the pad.
module mdio_phy_slave
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR    = 5'h04,
    parameter int         MIN_PRE     = 32,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eth_mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_data,
    output logic        reg_rd_req,
    input  logic [15:0] reg_rd_data,
    output logic        busy,
    output logic        frame_err
);

    localparam logic [PRE_CNT_W-1:0] PRE_SAT   = PRE_CNT_W'(32);
    localparam logic [PRE_CNT_W-1:0] MIN_PRE_C = PRE_CNT_W'(MIN_PRE);

    logic                 mdc_rise;
    logic                 mdio_s;
    mdio_state_t          state;
    logic [PRE_CNT_W-1:0] pre_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [15:0]          shreg;
    logic                 is_rd;
    logic                 rd_latch;

    function automatic logic [PRE_CNT_W-1:0] pre_inc(input logic [PRE_CNT_W-1:0] c);
        return (c >= PRE_SAT) ? PRE_SAT : c + 1'b1;
    endfunction

    mdio_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .eth_mdc  (eth_mdc),
        .mdio_i   (mdio_i),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            is_rd       <= 1'b0;
            rd_latch    <= 1'b0;
            mdio_o      <= 1'b0;
            mdio_oe     <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_req  <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            reg_wr_en  <= 1'b0;
            reg_rd_req <= 1'b0;
            frame_err  <= 1'b0;
            // Read data arrives one clk after the request; capture it the cycle after that.
            rd_latch   <= reg_rd_req;
            if (rd_latch) shreg <= reg_rd_data;

            if (mdc_rise) begin
                case (state)
                    S_IDLE: begin
                        if (mdio_s) begin
                            pre_cnt <= pre_inc(pre_cnt);
                        end else begin
                            pre_cnt <= '0;
                            if (pre_cnt >= MIN_PRE_C) begin
                                state <= S_ST;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    S_ST: begin
                        if (mdio_s) begin
                            state   <= S_OP;
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    S_OP: begin
                        if (bit_cnt == 4'd0) begin
                            shreg[0] <= mdio_s;
                            bit_cnt  <= 4'd1;
                        end else if ({shreg[0], mdio_s} == MDIO_OP_RD ||
                                     {shreg[0], mdio_s} == MDIO_OP_WR) begin
                            is_rd   <= ({shreg[0], mdio_s} == MDIO_OP_RD);
                            state   <= S_PHYAD;
                            bit_cnt <= '0;
                        end else begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            mdio_oe   <= 1'b0;
                            pre_cnt   <= '0;
                        end
                    end
                    S_PHYAD: begin
                        shreg <= {shreg[14:0], mdio_s};
                        if (bit_cnt == 4'd4) begin
                            bit_cnt <= '0;
                            if ({shreg[3:0], mdio_s} == PHY_ADDR) begin
                                state <= S_REGAD;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_REGAD: begin
                        shreg <= {shreg[14:0], mdio_s};
                        if (bit_cnt == 4'd4) begin
                            bit_cnt    <= '0;
                            reg_addr   <= {shreg[3:0], mdio_s};
                            reg_rd_req <= is_rd;
                            state      <= is_rd ? S_RD_TA1 : S_WR_TA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_RD_TA1: begin
                        mdio_oe <= 1'b1;
                        mdio_o  <= 1'b0;
                        state   <= S_RD_TA2;
                    end
                    S_RD_TA2: begin
                        mdio_o  <= shreg[15];
                        shreg   <= {shreg[14:0], 1'b0};
                        bit_cnt <= '0;
                        state   <= S_RD_DATA;
                    end
                    S_RD_DATA: begin
                        // Bit 15 went out in TA2, so 15 more rises present bits 14..0.
                        if (bit_cnt == 4'd15) begin
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b0;
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            mdio_o  <= shreg[15];
                            shreg   <= {shreg[14:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_WR_TA: begin
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                        end else if (mdio_s) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            mdio_oe   <= 1'b0;
                            pre_cnt   <= '0;
                        end else begin
                            state   <= S_WR_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_WR_DATA: begin
                        shreg <= {shreg[14:0], mdio_s};
                        if (bit_cnt == 4'd15) begin
                            reg_wr_data <= {shreg[14:0], mdio_s};
                            reg_wr_en   <= 1'b1;
                            state       <= S_IDLE;
                            busy        <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        mdio_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_slave.sv
// Directed bench for mdio_phy_slave: a station-management master model drives
// MDC/MDIO frames and the register port is watched by a strobe monitor.
module tb_mdio_phy_slave;

    localparam time HALF = 80ns;

    logic        clk = 1'b0;
    logic        rst;
    logic        eth_mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic [4:0]  reg_addr;
    logic        reg_wr_en;
    logic [15:0] reg_wr_data;
    logic        reg_rd_req;
    logic [15:0] reg_rd_data;
    logic        busy;
    logic        frame_err;

    logic m_oe;
    logic m_bit;

    int n_vec = 0;
    int n_err = 0;

    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cyc = 0, both_cnt = 0;
    logic [4:0]  wr_addr_log [16];
    logic [15:0] wr_data_log [16];

    always #5ns clk = ~clk;

    // Pad: DUT has priority when enabled, otherwise master, otherwise pull-up.
    assign mdio_i = mdio_oe ? mdio_o : (m_oe ? m_bit : 1'b1);

    mdio_phy_slave #(
        .PHY_ADDR    (5'h04),
        .MIN_PRE     (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .eth_mdc     (eth_mdc),
        .mdio_i      (mdio_i),
        .mdio_o      (mdio_o),
        .mdio_oe     (mdio_oe),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_req  (reg_rd_req),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_addr_log[wr_cnt[3:0]] = reg_addr;
            wr_data_log[wr_cnt[3:0]] = reg_wr_data;
            wr_cnt++;
        end
        if (reg_rd_req) rd_cnt++;
        if (frame_err) err_cnt++;
        if (mdio_oe) oe_cyc++;
        if (reg_wr_en && reg_rd_req) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One MDC period: master bit set while low, pad sampled just before the rise.
    task automatic mdc_cycle(input logic b, output logic s, output logic s_oe);
        m_bit   = b;
        eth_mdc = 1'b0;
        #(HALF);
        s       = mdio_i;
        s_oe    = mdio_oe;
        eth_mdc = 1'b1;
        #(HALF);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic s, so;
        m_oe = 1'b1;
        for (int i = n - 1; i >= 0; i--) mdc_cycle(v[i], s, so);
    endtask

    task automatic preamble(input int n);
        logic s, so;
        m_oe = 1'b1;
        for (int i = 0; i < n; i++) mdc_cycle(1'b1, s, so);
    endtask

    task automatic mdio_write(input int npre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] regad, input logic [15:0] data);
        preamble(npre);
        send_bits(32'(2'b01), 2);
        send_bits(32'(op), 2);
        send_bits(32'(phy), 5);
        send_bits(32'(regad), 5);
        send_bits(32'(2'b10), 2);
        send_bits(32'(data), 16);
        repeat (4) @(negedge clk);
    endtask

    task automatic mdio_read(input logic [4:0] phy, input logic [4:0] regad, input int nbits,
                             output logic [15:0] data, output logic ta1, output logic oe1,
                             output logic ta2, output logic oe2, output logic busy_mid);
        logic s, so;
        preamble(32);
        send_bits(32'(2'b01), 2);
        send_bits(32'(2'b10), 2);
        send_bits(32'(phy), 5);
        send_bits(32'(regad), 5);
        m_oe = 1'b0;
        busy_mid = busy;
        mdc_cycle(1'b1, ta1, oe1);
        mdc_cycle(1'b1, ta2, oe2);
        data = '0;
        for (int i = 0; i < nbits; i++) begin
            mdc_cycle(1'b1, s, so);
            data = {data[14:0], s};
        end
    endtask

    initial begin
        int w0, r0, e0, o0;
        logic [15:0] rdat;
        logic ta1, oe1, ta2, oe2, bm;

        rst = 1'b1; eth_mdc = 1'b0; m_oe = 1'b1; m_bit = 1'b1; reg_rd_data = 16'h0000;
        repeat (5) @(negedge clk);
        check("rst_mdio_o", 32'(mdio_o), 0);
        check("rst_mdio_oe", 32'(mdio_oe), 0);
        check("rst_reg_addr", 32'(reg_addr), 0);
        check("rst_wr_en", 32'(reg_wr_en), 0);
        check("rst_wr_data", 32'(reg_wr_data), 0);
        check("rst_rd_req", 32'(reg_rd_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write 0x00 <- 0x1140
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cyc;
        mdio_write(32, 2'b01, 5'h04, 5'h00, 16'h1140);
        check("wr_strobes", 32'(wr_cnt - w0), 1);
        check("wr_addr", 32'(wr_addr_log[w0[3:0]]), 32'h00);
        check("wr_data", 32'(wr_data_log[w0[3:0]]), 32'h1140);
        check("wr_no_oe", 32'(oe_cyc - o0), 0);
        check("wr_no_rdreq", 32'(rd_cnt - r0), 0);
        check("wr_no_err", 32'(err_cnt - e0), 0);
        check("wr_busy_end", 32'(busy), 0);

        // Read 0x02 -> 0x0022
        reg_rd_data = 16'h0022;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        mdio_read(5'h04, 5'h02, 16, rdat, ta1, oe1, ta2, oe2, bm);
        check("rd_busy_mid", 32'(bm), 1);
        check("rd_ta1_released", 32'(oe1), 0);
        check("rd_ta1_pullup", 32'(ta1), 1);
        check("rd_ta2_oe", 32'(oe2), 1);
        check("rd_ta2_zero", 32'(ta2), 0);
        check("rd_data", 32'(rdat), 32'h0022);
        repeat (6) @(negedge clk);
        check("rd_oe_released", 32'(mdio_oe), 0);
        check("rd_busy_end", 32'(busy), 0);
        check("rd_req_once", 32'(rd_cnt - r0), 1);
        check("rd_no_wr", 32'(wr_cnt - w0), 0);
        check("rd_reg_addr", 32'(reg_addr), 32'h02);
        check("rd_no_err", 32'(err_cnt - e0), 0);

        // Read to the wrong PHY address is ignored silently
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cyc;
        mdio_read(5'h05, 5'h00, 16, rdat, ta1, oe1, ta2, oe2, bm);
        repeat (6) @(negedge clk);
        check("phy_no_rdreq", 32'(rd_cnt - r0), 0);
        check("phy_no_wr", 32'(wr_cnt - w0), 0);
        check("phy_no_oe", 32'(oe_cyc - o0), 0);
        check("phy_no_err", 32'(err_cnt - e0), 0);

        // 31-bit preamble write is ignored
        send_bits(32'h0, 1);
        w0 = wr_cnt; e0 = err_cnt;
        mdio_write(31, 2'b01, 5'h04, 5'h00, 16'h1140);
        check("short_no_wr", 32'(wr_cnt - w0), 0);
        check("short_no_err", 32'(err_cnt - e0), 0);

        // OP 11 aborts with frame_err
        w0 = wr_cnt; e0 = err_cnt;
        mdio_write(32, 2'b11, 5'h04, 5'h00, 16'h1140);
        check("badop_err", 32'(err_cnt - e0), 1);
        check("badop_no_wr", 32'(wr_cnt - w0), 0);

        // Reset asserted while RD_DATA bit 7 is on the pad
        reg_rd_data = 16'h00FF;
        mdio_read(5'h04, 5'h01, 8, rdat, ta1, oe1, ta2, oe2, bm);
        repeat (5) @(negedge clk);
        check("mid_oe_before", 32'(mdio_oe), 1);
        check("mid_bits_15_8", 32'(rdat[7:0]), 32'h00);
        rst = 1'b1;
        #1ns;
        check("mid_oe_async", 32'(mdio_oe), 0);
        check("mid_busy_async", 32'(busy), 0);
        eth_mdc = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        reg_rd_data = 16'hBEEF;
        r0 = rd_cnt;
        mdio_read(5'h04, 5'h1F, 16, rdat, ta1, oe1, ta2, oe2, bm);
        repeat (6) @(negedge clk);
        check("post_rst_ta2", 32'(ta2), 0);
        check("post_rst_data", 32'(rdat), 32'hBEEF);
        check("post_rst_rdreq", 32'(rd_cnt - r0), 1);
        check("post_rst_oe_off", 32'(mdio_oe), 0);

        // Back-to-back writes
        w0 = wr_cnt;
        mdio_write(32, 2'b01, 5'h04, 5'h03, 16'hAAAA);
        mdio_write(32, 2'b01, 5'h04, 5'h04, 16'h5555);
        check("b2b_strobes", 32'(wr_cnt - w0), 2);
        check("b2b_addr0", 32'(wr_addr_log[w0[3:0]]), 32'h03);
        check("b2b_data0", 32'(wr_data_log[w0[3:0]]), 32'hAAAA);
        check("b2b_addr1", 32'(wr_addr_log[4'(w0 + 1)]), 32'h04);
        check("b2b_data1", 32'(wr_data_log[4'(w0 + 1)]), 32'h5555);
        check("never_wr_and_rd", 32'(both_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
